// File: rtl/kyo_sprite_fetch.sv
// kyo_sprite_fetch: turns the VGA scan position and the character position into
// a sprite ROM address for the renderer, and runs the stand-animation frame
// sequencer that steps through the frames stacked in the sprite ROM.
module kyo_sprite_fetch #(
   parameter int SPR_W      = 64,
   parameter int SPR_H      = 96,
   parameter int NUM_FRAMES = 8,
   parameter int HOLD_VS    = 6
) (
   input  logic        vga_clk,
   input  logic        reset_n,
   input  logic [9:0]  draw_x,
   input  logic [9:0]  draw_y,
   input  logic        blank,
   input  logic        vsync,
   input  logic [9:0]  pos_x,
   input  logic [9:0]  pos_y,
   input  logic        flip,
   input  logic        anim_en,
   output logic [15:0] rom_address,
   output logic        sprite_hit,
   output logic [2:0]  frame_idx
);

   localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
   localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
   localparam int HW = (HOLD_VS > 1) ? $clog2(HOLD_VS) : 1;
   localparam logic [15:0] FRAME_SIZE = 16'(SPR_W * SPR_H);

   typedef enum logic {SEQ_IDLE, SEQ_RUN} seq_state_t;

   seq_state_t    seq_state;
   logic          vsync_q;
   logic          vs_fall;
   logic [9:0]    px_l, py_l;
   logic          flip_l;
   logic [HW-1:0] hold, hold_next;
   logic [2:0]    frame_next;
   logic [15:0]   frame_base, base_next;
   logic [10:0]   dx, dy;
   logic          hit_c;
   logic [CW-1:0] col_c;
   logic          hit1;
   logic [CW-1:0] col1;
   logic [RW-1:0] row1;

   assign vs_fall = vsync_q & ~vsync;

   // Detect the vsync falling edge and latch position/facing there, so the
   // hit test never sees a position change in the middle of a frame.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         vsync_q <= 1'b1;
         px_l    <= '0;
         py_l    <= '0;
         flip_l  <= 1'b0;
      end else begin
         vsync_q <= vsync;
         if (vs_fall) begin
            px_l   <= pos_x;
            py_l   <= pos_y;
            flip_l <= flip;
         end
      end
   end

   // Sequencer next-state: RUN counts vsync edges and advances the frame every
   // HOLD_VS edges; IDLE freezes everything so re-enabling resumes mid-hold.
   // frame_base is accumulated so no multiplier is needed.
   always_comb begin
      seq_state  = anim_en ? SEQ_RUN : SEQ_IDLE;
      hold_next  = hold;
      frame_next = frame_idx;
      base_next  = frame_base;
      case (seq_state)
         SEQ_RUN: begin
            if (vs_fall) begin
               if (hold == HW'(HOLD_VS - 1)) begin
                  hold_next = '0;
                  if (frame_idx == 3'(NUM_FRAMES - 1)) begin
                     frame_next = '0;
                     base_next  = '0;
                  end else begin
                     frame_next = frame_idx + 3'd1;
                     base_next  = frame_base + FRAME_SIZE;
                  end
               end else begin
                  hold_next = hold + HW'(1);
               end
            end
         end
         default: ;
      endcase
   end

   // Sequencer state registers.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         hold       <= '0;
         frame_idx  <= '0;
         frame_base <= '0;
      end else begin
         hold       <= hold_next;
         frame_idx  <= frame_next;
         frame_base <= base_next;
      end
   end

   // Box test: 11-bit differences so a negative offset shows up in bit 10 and
   // a sprite hanging off the right edge never wraps to the left.
   always_comb begin
      dx    = {1'b0, draw_x} - {1'b0, px_l};
      dy    = {1'b0, draw_y} - {1'b0, py_l};
      hit_c = blank & ~dx[10] & (dx[9:0] < 10'(SPR_W))
                    & ~dy[10] & (dy[9:0] < 10'(SPR_H));
      col_c = flip_l ? (CW'(SPR_W - 1) - dx[CW-1:0]) : dx[CW-1:0];
   end

   // Stage 1: register hit, column and row.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         hit1 <= 1'b0;
         col1 <= '0;
         row1 <= '0;
      end else begin
         hit1 <= hit_c;
         col1 <= col_c;
         row1 <= dy[RW-1:0];
      end
   end

   // Stage 2: form the ROM address; SPR_W is a power of two so row*SPR_W+col
   // is just the concatenation. Misses drive address 0.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         rom_address <= '0;
         sprite_hit  <= 1'b0;
      end else begin
         rom_address <= hit1 ? (frame_base + 16'({row1, col1})) : 16'd0;
         sprite_hit  <= hit1;
      end
   end

endmodule

// File: tb/tb_kyo_sprite_fetch.sv
// tb_kyo_sprite_fetch: directed scan vectors push expected outputs into a
// scoreboard queue; a monitor on the falling clock edge pops and compares
// them two cycles after each vector is driven.
module tb_kyo_sprite_fetch;

   localparam int FRAME = 64 * 96;

   logic        vga_clk = 1'b0;
   logic        reset_n;
   logic [9:0]  draw_x, draw_y, pos_x, pos_y;
   logic        blank, vsync, flip, anim_en;
   logic [15:0] rom_address;
   logic        sprite_hit;
   logic [2:0]  frame_idx;

   typedef struct {
      int          due;
      int          id;
      logic        hit;
      logic [15:0] addr;
   } exp_t;

   exp_t sb[$];
   exp_t monEntry;
   int   cycle   = 0;
   int   nChecks = 0;
   int   nFails  = 0;
   int   pixId   = 0;

   kyo_sprite_fetch dut (
      .vga_clk    (vga_clk),
      .reset_n    (reset_n),
      .draw_x     (draw_x),
      .draw_y     (draw_y),
      .blank      (blank),
      .vsync      (vsync),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .flip       (flip),
      .anim_en    (anim_en),
      .rom_address(rom_address),
      .sprite_hit (sprite_hit),
      .frame_idx  (frame_idx)
   );

   // Pixel clock.
   always #5 vga_clk = ~vga_clk;

   // Cycle counter used to schedule scoreboard entries.
   always @(posedge vga_clk) cycle <= cycle + 1;

   // Safety net in case the run stalls.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input int id,
                              input logic [31:0] act, input logic [31:0] req);
      nChecks++;
      if (act !== req) begin
         nFails++;
         $display("[TB] FAIL %s #%0d actual=0x%0h required=0x%0h", name, id, act, req);
      end
   endtask

   // Monitor: compare each scoreboard entry on the cycle its result is due.
   always @(negedge vga_clk) begin
      while (sb.size() > 0 && sb[0].due <= cycle) begin
         monEntry = sb.pop_front();
         checkOutput("pix_hit", monEntry.id, {31'd0, sprite_hit}, {31'd0, monEntry.hit});
         checkOutput("pix_addr", monEntry.id, {16'd0, rom_address}, {16'd0, monEntry.addr});
      end
   end

   // Drive one scan pixel for one cycle and queue its expected response.
   task automatic applyStimulus(input int x, input int y, input logic bl,
                                input logic expHit, input logic [15:0] expAddr);
      exp_t e;
      @(posedge vga_clk);
      #1;
      draw_x = 10'(x);
      draw_y = 10'(y);
      blank  = bl;
      e.due  = cycle + 2;
      e.id   = pixId++;
      e.hit  = expHit;
      e.addr = expAddr;
      sb.push_back(e);
   endtask

   // One vsync low pulse (falling edge seen once), visible area blanked.
   task automatic vsyncPulse();
      @(posedge vga_clk);
      #1;
      blank = 1'b0;
      vsync = 1'b0;
      @(posedge vga_clk);
      @(posedge vga_clk);
      #1;
      vsync = 1'b1;
   endtask

   // Reference for sweeps: position, flip and frame base given explicitly.
   task automatic expPix(input int x, input int y, input logic bl, input int px,
                         input int py, input logic fl, input int base,
                         output logic h, output logic [15:0] a);
      int ddx, ddy;
      ddx = x - px;
      ddy = y - py;
      h = bl && ddx >= 0 && ddx < 64 && ddy >= 0 && ddy < 96;
      a = h ? 16'(base + ddy * 64 + (fl ? 63 - ddx : ddx)) : 16'd0;
   endtask

   initial begin
      logic        h;
      logic [15:0] a;
      reset_n = 1'b0;
      vsync   = 1'b1;
      blank   = 1'b0;
      draw_x  = '0;
      draw_y  = '0;
      pos_x   = '0;
      pos_y   = '0;
      flip    = 1'b0;
      anim_en = 1'b0;

      // Reset state.
      repeat (3) @(posedge vga_clk);
      #1;
      checkOutput("rst_addr", 0, {16'd0, rom_address}, 32'd0);
      checkOutput("rst_hit", 0, {31'd0, sprite_hit}, 32'd0);
      checkOutput("rst_frame", 0, {29'd0, frame_idx}, 32'd0);
      @(negedge vga_clk);
      reset_n = 1'b1;

      // Unflipped sprite at (100,200), animation idle.
      pos_x = 10'd100;
      pos_y = 10'd200;
      vsyncPulse();
      applyStimulus(100, 200, 1'b1, 1'b1, 16'h0000);
      applyStimulus(163, 295, 1'b1, 1'b1, 16'h17FF);
      applyStimulus(99, 200, 1'b1, 1'b0, 16'h0000);
      applyStimulus(100, 296, 1'b1, 1'b0, 16'h0000);
      applyStimulus(164, 200, 1'b1, 1'b0, 16'h0000);
      applyStimulus(100, 200, 1'b0, 1'b0, 16'h0000);
      applyStimulus(101, 201, 1'b1, 1'b1, 16'h0041);

      // Mirrored.
      flip = 1'b1;
      vsyncPulse();
      applyStimulus(100, 200, 1'b1, 1'b1, 16'h003F);
      applyStimulus(163, 200, 1'b1, 1'b1, 16'h0000);
      applyStimulus(164, 200, 1'b1, 1'b0, 16'h0000);
      applyStimulus(101, 201, 1'b1, 1'b1, 16'h007E);

      // Animation: 6 edges advance one frame.
      flip    = 1'b0;
      anim_en = 1'b1;
      repeat (6) vsyncPulse();
      checkOutput("frame_after6", 0, {29'd0, frame_idx}, 32'd1);
      applyStimulus(100, 200, 1'b1, 1'b1, 16'h1800);
      // Freeze mid-hold, then resume.
      repeat (3) vsyncPulse();
      anim_en = 1'b0;
      repeat (5) vsyncPulse();
      checkOutput("frame_frozen", 0, {29'd0, frame_idx}, 32'd1);
      anim_en = 1'b1;
      repeat (3) vsyncPulse();
      checkOutput("frame_resume", 0, {29'd0, frame_idx}, 32'd2);
      applyStimulus(100, 200, 1'b1, 1'b1, 16'h3000);
      repeat (36) vsyncPulse();
      checkOutput("frame_wrap", 0, {29'd0, frame_idx}, 32'd0);
      applyStimulus(100, 200, 1'b1, 1'b1, 16'h0000);

      // Position change mid-frame does not tear.
      anim_en = 1'b0;
      for (int x = 90; x <= 170; x++) begin
         if (x == 130) pos_x = 10'd300;
         expPix(x, 250, 1'b1, 100, 200, 1'b0, 0, h, a);
         applyStimulus(x, 250, 1'b1, h, a);
      end
      vsyncPulse();
      applyStimulus(100, 250, 1'b1, 1'b0, 16'h0000);
      for (int x = 290; x <= 370; x++) begin
         expPix(x, 250, 1'b1, 300, 200, 1'b0, 0, h, a);
         applyStimulus(x, 250, 1'b1, h, a);
      end

      // Sprite hanging off the right edge.
      pos_x = 10'd600;
      vsyncPulse();
      for (int x = 595; x <= 639; x++) begin
         expPix(x, 200, 1'b1, 600, 200, 1'b0, 0, h, a);
         applyStimulus(x, 200, 1'b1, h, a);
      end
      for (int x = 640; x <= 703; x++) applyStimulus(x, 200, 1'b0, 1'b0, 16'h0000);

      // Reset mid-animation at frame 5.
      anim_en = 1'b1;
      repeat (30) vsyncPulse();
      checkOutput("frame_five", 0, {29'd0, frame_idx}, 32'd5);
      applyStimulus(600, 200, 1'b1, 1'b1, 16'(5 * FRAME));
      repeat (3) @(posedge vga_clk);
      #3;
      reset_n = 1'b0;
      #1;
      checkOutput("async_addr", 0, {16'd0, rom_address}, 32'd0);
      checkOutput("async_hit", 0, {31'd0, sprite_hit}, 32'd0);
      checkOutput("async_frame", 0, {29'd0, frame_idx}, 32'd0);
      blank = 1'b0;
      repeat (3) @(posedge vga_clk);
      @(negedge vga_clk);
      reset_n = 1'b1;

      // Latched position is back to (0,0) until the next vsync edge.
      applyStimulus(10, 5, 1'b1, 1'b1, 16'h014A);
      applyStimulus(600, 200, 1'b1, 1'b0, 16'h0000);
      // Hold count restarted from zero.
      repeat (5) vsyncPulse();
      checkOutput("hold_restart5", 0, {29'd0, frame_idx}, 32'd0);
      vsyncPulse();
      checkOutput("hold_restart6", 0, {29'd0, frame_idx}, 32'd1);
      applyStimulus(600, 200, 1'b1, 1'b1, 16'(FRAME));

      repeat (4) @(posedge vga_clk);
      #1;
      checkOutput("sb_drain", 0, 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/kyo_sprite_fetch.md
Name: kyo_sprite_fetch

Overview:
Address-generation stage directly upstream of the character sprite renderer. It takes the VGA scan position and the character's screen position, and decides whether the current pixel lies inside the sprite box. It then produces the 16-bit sprite ROM address that the renderer consumes. It also runs the stand-animation frame sequencer, which advances on vertical sync and steps through the frames stacked in the sprite ROM.

Parameters:
SPR_W, 64, sprite width in pixels; must be a power of two
SPR_H, 96, sprite height in pixels
NUM_FRAMES, 8, animation frames stacked contiguously in ROM; NUM_FRAMES*SPR_W*SPR_H ≤ 65536
HOLD_VS, 6, vsync periods each animation frame is displayed

Ports:
vga_clk  input  1  pixel clock; all state on posedge
reset_n  input  1  asynchronous active-low reset
draw_x  input  10  current scan column
draw_y  input  10  current scan row
blank  input  1  high = visible region (same polarity the renderer uses)
vsync  input  1  VGA vsync, active low
pos_x  input  10  sprite top-left column (game logic domain, may change any time)
pos_y  input  10  sprite top-left row
flip  input  1  1 = mirror horizontally (facing left)
anim_en  input  1  1 = animation advances
rom_address  output  16  sprite ROM address to renderer
sprite_hit  output  1  rom_address refers to an in-box, visible pixel
frame_idx  output  3  current animation frame (debug/HUD)

Behaviour:
- Reset (reset_n low, asynchronous): rom_address=0, sprite_hit=0, frame_idx=0, frame_base=0, hold counter=0, latched position=0, vsync edge register=1, all pipeline registers=0.
- Position latch: on the vsync falling edge (prev=1, now=0), capture pos_x, pos_y, and flip into px_l, py_l, and flip_l. Only the latched values are used for hit testing, so there is no tearing mid-frame.
- Sequencer states: IDLE (anim_en=0) and RUN (anim_en=1). This is level-driven, with no extra latency.
- RUN, on each vsync falling edge:
  - If hold==HOLD_VS-1: hold←0 and advance the frame.
  - Otherwise: hold←hold+1.
- Frame advance:
  - If frame_idx==NUM_FRAMES-1: frame_idx←0, frame_base←0 (wrap).
  - Otherwise: frame_idx+1, frame_base←frame_base+SPR_W*SPR_H.
  - frame_base is an accumulator; no multiplier is used.
- IDLE: hold and frame_idx freeze at their current values. anim_en returning to 1 resumes from the frozen hold value.
- The position latch and the frame advance occur on the same edge. Both take effect on the next vsync-low cycle, and both are stable for the whole visible frame.
- Pipeline, stage 1 (registered):
  - dx = draw_x − px_l and dy = draw_y − py_l, computed as 11-bit signed.
  - hit1 = blank & (0 ≤ dx < SPR_W) & (0 ≤ dy < SPR_H).
  - col1 = flip_l ? SPR_W−1−dx : dx (log2 SPR_W bits).
  - row1 = dy (7 bits).
- Pipeline, stage 2 (registered):
  - If hit1: rom_address = frame_base + (row1 concatenated with col1), i.e. row1*SPR_W+col1.
  - If not hit1: rom_address holds 0.
  - sprite_hit = hit1.
- Latency: draw_x/draw_y to rom_address/sprite_hit is 2 vga_clk cycles. The upstream scan counter must lead by 2 cycles plus the renderer latency.
- Boundaries:
  - A sprite partly off-screen (px_l+SPR_W > 640) only hits the visible columns; there is no wrap to the left edge, which the 11-bit compare guarantees.
  - draw_x in 640–799 or blank low gives no hit.
  - Address arithmetic is 16-bit. The overflow-free parameter constraint above is a design rule and is not checked at runtime.
- Reset asserted mid-frame clears all state immediately. Outputs read 0 until the first valid pixel after deassertion. The first frame after reset uses position 0,0 until the next vsync falling edge.

Test Plan:
- Reset, then anim_en=0, pos=(100,200) latched by one vsync, scan (100,200) → two cycles later rom_address=0x0000, sprite_hit=1; scan (163,295) → 0x17FF.
- Same setup with flip=1, scan (100,200) → rom_address=0x003F; scan (164,200) → sprite_hit=0, rom_address=0.
- anim_en=1, HOLD_VS=6: apply 6 vsync falling edges → frame_idx=1; scan (100,200) → rom_address=0x1800. After 48 edges total → frame_idx=0, frame_base=0 (wrap).
- Change pos_x to 300 mid-frame while scanning row 250 → remaining pixels still hit at x=100–163; after the next vsync edge, hits are at x=300–363 only.
- pos_x=600, scan row py_l: hits for x=600–639 only; x=640–703 with blank=0 → sprite_hit=0 throughout.
- Assert reset_n low for 3 cycles mid-animation at frame_idx=5 → frame_idx=0, rom_address=0, sprite_hit=0 asynchronously; after release, the hold count restarts from 0.
